// File: rtl/instruction_sequencer.sv
// Issues fetched instructions one at a time, holding the 4-bit class on selector for its execution length.
// Latency: accept at edge N drives selector/operands in cycles N+1..N+C; retire is high in cycle N+C.
// Backpressure: instr_ready is low mid-instruction and during flush/rst; a retire cycle can accept the next instruction.
module instruction_sequencer #(
    parameter int BIN_CYCLES  = 1,
    parameter int UNAR_CYCLES = 1,
    parameter int INCR_CYCLES = 2,
    parameter int JUMP_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic        flush,
    output logic        instr_ready,
    output logic [3:0]  selector,
    output logic [2:0]  step,
    output logic [11:0] operands,
    output logic        busy,
    output logic        retire
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam bit PARAMS_LEGAL =
        (BIN_CYCLES  >= 1) && (BIN_CYCLES  <= 7) &&
        (UNAR_CYCLES >= 1) && (UNAR_CYCLES <= 7) &&
        (INCR_CYCLES >= 1) && (INCR_CYCLES <= 7) &&
        (JUMP_CYCLES >= 1) && (JUMP_CYCLES <= 7);

    state_t      state_q, state_d;
    logic [3:0]  sel_q;
    logic [2:0]  step_q;
    logic [2:0]  cyc_q;
    logic [11:0] opnd_q;
    logic        last;
    logic        accept;

    function automatic logic [2:0] cycles_for(input logic [3:0] opcode);
        case (opcode)
            4'h0:    cycles_for = 3'd1;
            4'hD:    cycles_for = 3'(UNAR_CYCLES);
            4'hE:    cycles_for = 3'(INCR_CYCLES);
            4'hF:    cycles_for = 3'(JUMP_CYCLES);
            default: cycles_for = 3'(BIN_CYCLES);
        endcase
    endfunction

    // cyc_q is never 0 while executing, so the subtraction cannot wrap.
    assign last        = (state_q == EXEC) && (step_q == cyc_q - 3'd1);
    assign instr_ready = !rst && !flush && ((state_q == IDLE) || last);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = EXEC;
        end else if (last) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= 4'h0;
            step_q <= 3'd0;
            cyc_q  <= 3'd1;
            opnd_q <= 12'h000;
        end else if (flush || (last && !accept)) begin
            sel_q  <= 4'h0;
            step_q <= 3'd0;
        end else if (accept) begin
            sel_q  <= instr[15:12];
            opnd_q <= instr[11:0];
            step_q <= 3'd0;
            cyc_q  <= cycles_for(instr[15:12]);
        end else if (state_q == EXEC) begin
            step_q <= step_q + 3'd1;
        end
    end

    always_comb begin
        selector = sel_q;
        step     = step_q;
        operands = opnd_q;
        busy     = (state_q == EXEC);
        retire   = last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (PARAMS_LEGAL)
            else $error("instruction_sequencer: cycle parameters must be in 1..7");
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: inputs change 2ns after a rising edge, outputs checked before the next edge.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        flush;
    logic        instr_ready;
    logic [3:0]  selector;
    logic [2:0]  step;
    logic [11:0] operands;
    logic        busy;
    logic        retire;

    int total = 0;
    int bad   = 0;

    instruction_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .flush       (flush),
        .instr_ready (instr_ready),
        .selector    (selector),
        .step        (step),
        .operands    (operands),
        .busy        (busy),
        .retire      (retire)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; flush = 1'b0;
        tick(); tick();
        #1;
        total++; if (selector !== 4'h0)    begin bad++; $display("FAIL reset_selector got=%h want=0", selector); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (retire !== 1'b0)      begin bad++; $display("FAIL reset_retire got=%b want=0", retire); end
        total++; if (step !== 3'd0)        begin bad++; $display("FAIL reset_step got=%0d want=0", step); end
        total++; if (operands !== 12'h000) begin bad++; $display("FAIL reset_operands got=%h want=000", operands); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b want=0", instr_ready); end
        rst = 1'b0;
        #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", instr_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (selector !== 4'h0 || busy !== 1'b0 || instr_ready !== 1'b1)
                begin bad++; $display("FAIL idle_cycle%0d got sel=%h busy=%b rdy=%b want sel=0 busy=0 rdy=1", i, selector, busy, instr_ready); end
        end
    endtask

    task automatic test_single();
        instr_valid = 1'b1; instr = 16'h3A5C;
        tick();
        instr_valid = 1'b0;
        #1;
        total++; if (selector !== 4'h3)    begin bad++; $display("FAIL single_selector got=%h want=3", selector); end
        total++; if (operands !== 12'hA5C) begin bad++; $display("FAIL single_operands got=%h want=a5c", operands); end
        total++; if (step !== 3'd0)        begin bad++; $display("FAIL single_step got=%0d want=0", step); end
        total++; if (retire !== 1'b1 || busy !== 1'b1)
            begin bad++; $display("FAIL single_retire got retire=%b busy=%b want 1 1", retire, busy); end
        tick();
        total++; if (selector !== 4'h0 || busy !== 1'b0 || retire !== 1'b0)
            begin bad++; $display("FAIL single_idle got sel=%h busy=%b retire=%b want 0 0 0", selector, busy, retire); end
        total++; if (operands !== 12'hA5C) begin bad++; $display("FAIL single_operands_hold got=%h want=a5c", operands); end
    endtask

    task automatic test_back_to_back();
        instr_valid = 1'b1; instr = 16'hF012;
        tick();
        instr = 16'hD001;
        #1;
        for (int s = 0; s < 3; s++) begin
            total++; if (selector !== 4'hF || step !== 3'(s))
                begin bad++; $display("FAIL jump_step%0d got sel=%h step=%0d want sel=f step=%0d", s, selector, step, s); end
            total++; if (instr_ready !== (s == 2) || retire !== (s == 2))
                begin bad++; $display("FAIL jump_ready_retire%0d got rdy=%b retire=%b want %b %b", s, instr_ready, retire, s == 2, s == 2); end
            if (s < 2) begin tick(); #1; end
        end
        tick();
        instr_valid = 1'b0;
        #1;
        total++; if (selector !== 4'hD || operands !== 12'h001 || step !== 3'd0 || retire !== 1'b1)
            begin bad++; $display("FAIL b2b_unary got sel=%h op=%h step=%0d retire=%b want d 001 0 1", selector, operands, step, retire); end
        tick();
        total++; if (selector !== 4'h0 || busy !== 1'b0)
            begin bad++; $display("FAIL b2b_idle got sel=%h busy=%b want 0 0", selector, busy); end
    endtask

    task automatic test_flush();
        instr_valid = 1'b1; instr = 16'hE004;
        tick();
        instr = 16'h1234; flush = 1'b1;
        #1;
        total++; if (selector !== 4'hE || step !== 3'd0 || retire !== 1'b0)
            begin bad++; $display("FAIL flush_step0 got sel=%h step=%0d retire=%b want e 0 0", selector, step, retire); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", instr_ready); end
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        #1;
        total++; if (selector !== 4'h0 || busy !== 1'b0 || retire !== 1'b0 || step !== 3'd0)
            begin bad++; $display("FAIL flush_idle got sel=%h busy=%b retire=%b step=%0d want 0 0 0 0", selector, busy, retire, step); end
        total++; if (operands !== 12'h004) begin bad++; $display("FAIL flush_not_accepted got op=%h want=004", operands); end
        // Flush on the retire cycle still shows retire.
        instr_valid = 1'b1; instr = 16'h2ABC;
        tick();
        instr_valid = 1'b0; flush = 1'b1;
        #1;
        total++; if (retire !== 1'b1 || instr_ready !== 1'b0)
            begin bad++; $display("FAIL flush_on_retire got retire=%b rdy=%b want 1 0", retire, instr_ready); end
        tick();
        flush = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || selector !== 4'h0)
            begin bad++; $display("FAIL flush_retire_idle got busy=%b sel=%h want 0 0", busy, selector); end
    endtask

    task automatic test_null();
        instr_valid = 1'b1; instr = 16'h0000;
        tick();
        instr = 16'h1111;
        #1;
        total++; if (busy !== 1'b1 || selector !== 4'h0 || retire !== 1'b1 || instr_ready !== 1'b1)
            begin bad++; $display("FAIL null_cycle got busy=%b sel=%h retire=%b rdy=%b want 1 0 1 1", busy, selector, retire, instr_ready); end
        tick();
        instr_valid = 1'b0;
        #1;
        total++; if (selector !== 4'h1 || operands !== 12'h111 || retire !== 1'b1)
            begin bad++; $display("FAIL null_next got sel=%h op=%h retire=%b want 1 111 1", selector, operands, retire); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL null_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        instr_valid = 1'b1; instr = 16'hF0AB;
        tick();
        instr_valid = 1'b0;
        tick();
        #1;
        total++; if (step !== 3'd1 || selector !== 4'hF)
            begin bad++; $display("FAIL rstmid_pre got step=%0d sel=%h want 1 f", step, selector); end
        rst = 1'b1;
        tick();
        #1;
        total++; if (selector !== 4'h0 || step !== 3'd0 || operands !== 12'h000 || busy !== 1'b0 || retire !== 1'b0)
            begin bad++; $display("FAIL rstmid_outputs got sel=%h step=%0d op=%h busy=%b retire=%b want 0 0 000 0 0", selector, step, operands, busy, retire); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready_in_rst got=%b want=0", instr_ready); end
        rst = 1'b0;
        tick();
        total++; if (instr_ready !== 1'b1 || busy !== 1'b0 || retire !== 1'b0)
            begin bad++; $display("FAIL rstmid_after got rdy=%b busy=%b retire=%b want 1 0 0", instr_ready, busy, retire); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_null();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
